// File: rtl/packet_filler_pkg.sv
// Shared types and sizes for the packet ingress stage and packetmem.
package packet_filler_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 10;
  localparam int BYTE_ADDR_WIDTH = ADDR_WIDTH + 2;
  localparam int LEN_WIDTH       = BYTE_ADDR_WIDTH + 1;
  localparam int DROP_CNT_WIDTH  = 16;

  // Access-size codes understood by packetmem's filter-side read port.
  localparam logic [1:0] BPF_B = 2'd0;
  localparam logic [1:0] BPF_H = 2'd1;
  localparam logic [1:0] BPF_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_TRUNC,
    ST_HANDOFF,
    ST_DROP
  } pf_state_t;

  function automatic logic [2:0] last_beat_bytes(input logic [1:0] nb);
    return (nb == 2'b00) ? 3'd4 : {1'b0, nb};
  endfunction
endpackage

// File: rtl/packet_filler_if.sv
// Snoop stream in, packet-memory write port and filter handoff out.
interface packet_filler_if;
  import packet_filler_pkg::*;

  logic [DATA_WIDTH-1:0]     snoop_data;
  logic                      snoop_valid;
  logic                      snoop_last;
  logic [1:0]                snoop_bytes;
  logic                      buf_free;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      wr_en;
  logic                      done_valid;
  logic                      done_ack;
  logic [LEN_WIDTH-1:0]      byte_len;
  logic                      truncated;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  modport slave (
    input  snoop_data, snoop_valid, snoop_last, snoop_bytes, buf_free, done_ack,
    output wr_addr, wr_data, wr_en, done_valid, byte_len, truncated, drop_cnt
  );

  modport master (
    output snoop_data, snoop_valid, snoop_last, snoop_bytes, buf_free, done_ack,
    input  wr_addr, wr_data, wr_en, done_valid, byte_len, truncated, drop_cnt
  );
endinterface

// File: rtl/packet_filler_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module packet_filler_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/packet_filler.sv
// Writes snooped packets word-by-word into packet memory and hands each finished
// packet to the filter side; packets with no free buffer are dropped and counted.
//
//  state   | meaning
//  IDLE    | waiting for a packet start beat
//  FILL    | writing beats at consecutive word addresses
//  TRUNC   | memory full, discarding beats until last
//  HANDOFF | done_valid offered, waiting for done_ack
//  DROP    | discarding the rest of an unwanted packet
module packet_filler
  import packet_filler_pkg::*;
(
  input logic             clk,
  input logic             rst,
  packet_filler_if.slave  pf
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [LEN_WIDTH-1:0]  TRUNC_LEN = {1'b1, {BYTE_ADDR_WIDTH{1'b0}}};

  pf_state_t                 state_q, state_d;
  logic                      in_pkt_q, in_pkt_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      done_valid_q, done_valid_d;
  logic [LEN_WIDTH-1:0]      byte_len_q, byte_len_d;
  logic                      truncated_q, truncated_d;
  logic                      drop_inc;
  logic                      start;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  assign start = pf.snoop_valid && !in_pkt_q;

  always_comb begin
    state_d      = state_q;
    in_pkt_d     = in_pkt_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_valid_d = done_valid_q;
    byte_len_d   = byte_len_q;
    truncated_d  = truncated_q;
    drop_inc     = 1'b0;

    if (pf.snoop_valid) in_pkt_d = !pf.snoop_last;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pf.buf_free) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            wr_data_d   = pf.snoop_data;
            addr_d      = ADDR_WIDTH'(1);
            truncated_d = 1'b0;
            if (pf.snoop_last) begin
              state_d    = ST_HANDOFF;
              byte_len_d = LEN_WIDTH'(last_beat_bytes(pf.snoop_bytes));
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            drop_inc = 1'b1;
            if (!pf.snoop_last) state_d = ST_DROP;
          end
        end else if (pf.snoop_valid && !pf.snoop_last) begin
          state_d = ST_DROP;
        end
      end
      ST_FILL: begin
        if (pf.snoop_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pf.snoop_data;
          if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_WIDTH'(1);
          if (pf.snoop_last) begin
            state_d    = ST_HANDOFF;
            byte_len_d = {1'b0, addr_q, 2'b00} + LEN_WIDTH'(last_beat_bytes(pf.snoop_bytes));
          end else if (addr_q == ADDR_MAX) begin
            // Only the last word was left; the remainder of the packet is lost.
            state_d     = ST_TRUNC;
            truncated_d = 1'b1;
            byte_len_d  = TRUNC_LEN;
          end
        end
      end
      ST_TRUNC: begin
        if (pf.snoop_valid && pf.snoop_last) state_d = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (start) drop_inc = 1'b1;
        if (!done_valid_q) begin
          done_valid_d = 1'b1;
        end else if (pf.done_ack) begin
          done_valid_d = 1'b0;
          state_d      = in_pkt_d ? ST_DROP : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (pf.snoop_valid && pf.snoop_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_pkt_q     <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_valid_q <= 1'b0;
      byte_len_q   <= '0;
      truncated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_pkt_q     <= in_pkt_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_valid_q <= done_valid_d;
      byte_len_q   <= byte_len_d;
      truncated_q  <= truncated_d;
    end
  end

  packet_filler_sat_counter #(.WIDTH(DROP_CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  assign pf.wr_en      = wr_en_q;
  assign pf.wr_addr    = wr_addr_q;
  assign pf.wr_data    = wr_data_q;
  assign pf.done_valid = done_valid_q;
  assign pf.byte_len   = byte_len_q;
  assign pf.truncated  = truncated_q;
  assign pf.drop_cnt   = drop_cnt;
endmodule
